// File: rtl/pipe_stage_chain.sv
// Elastic register chain: per-stage valid/ready backpressure with kill, flush and
// an occupancy count. One word per cycle moves into a stage whose ready is high.

module pipe_stage_cell #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);
    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= valid_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

module pipe_stage_chain #(
    parameter int  DATA_W = 32,
    parameter int  STAGES = 5,
    localparam int CNT_W  = $clog2(STAGES + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    input  logic [STAGES-1:0]        kill,
    input  logic                     flush,
    output logic [STAGES-1:0]        stage_valid,
    output logic [STAGES*DATA_W-1:0] stage_data,
    output logic [CNT_W-1:0]         occupancy
);
    logic [STAGES-1:0]             valid_q, valid_d, ev, rdy;
    logic [STAGES-1:0][DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]              occ;

    // Ready ripples from the output back to the input through a single
    // running variable so the chain stays one combinational walk.
    always_comb begin
        logic r;
        ev  = '0;
        rdy = '0;
        r   = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            ev[i]  = valid_q[i] & ~kill[i] & ~flush;
            r      = ~ev[i] | r;
            rdy[i] = r;
        end
    end

    assign in_ready = rdy[0] & ~flush;

    always_comb begin
        valid_d    = '0;
        data_d     = '0;
        valid_d[0] = in_valid & in_ready;
        data_d[0]  = in_data;
        for (int i = 1; i < STAGES; i++) begin
            valid_d[i] = ev[i-1];
            data_d[i]  = data_q[i-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        pipe_stage_cell #(.DATA_W(DATA_W)) u_cell (
            .clock   (clock),
            .reset   (reset),
            .load_i  (rdy[g]),
            .valid_i (valid_d[g]),
            .data_i  (data_d[g]),
            .valid_o (valid_q[g]),
            .data_o  (data_q[g])
        );
    end

    // Registered view: kill bits in flight are not subtracted.
    always_comb begin
        occ = '0;
        for (int i = 0; i < STAGES; i++) occ = occ + CNT_W'(valid_q[i]);
    end

    assign occupancy   = occ;
    assign out_valid   = ev[STAGES-1];
    assign out_data    = data_q[STAGES-1];
    assign stage_valid = valid_q;
    assign stage_data  = data_q;
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench for pipe_stage_chain: stimulus pushes expected words, a
// negedge monitor pops and compares every output transfer.

module tb_pipe_stage_chain;
    localparam int DATA_W = 32;
    localparam int STAGES = 5;
    localparam int CNT_W  = $clog2(STAGES + 1);

    logic                     clock = 1'b0;
    logic                     reset = 1'b1;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [DATA_W-1:0]        in_data = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic [DATA_W-1:0]        out_data;
    logic [STAGES-1:0]        kill = '0;
    logic                     flush = 1'b0;
    logic [STAGES-1:0]        stage_valid;
    logic [STAGES*DATA_W-1:0] stage_data;
    logic [CNT_W-1:0]         occupancy;

    pipe_stage_chain #(.DATA_W(DATA_W), .STAGES(STAGES)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .kill(kill), .flush(flush),
        .stage_valid(stage_valid), .stage_data(stage_data), .occupancy(occupancy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q[$];
    bit occ_chk = 1'b0;
    int inflight = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Monitor: compare each output transfer against the scoreboard queue.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (occ_chk) begin
                    chk("occupancy_model", occupancy, inflight);
                    inflight += int'(in_valid && in_ready) - int'(out_valid && out_ready);
                end else begin
                    inflight = 0;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: got %0h, expected no output", out_data);
                    end else begin
                        chk("out_data", out_data, exp_q.pop_front());
                    end
                end
            end
        end
    end

    // Called at #1 after a rising edge; returns at #1 after the capture edge.
    task automatic send(input logic [DATA_W-1:0] w, input bit exp_out);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clock);
            if (in_ready) begin
                acc = 1'b1;
                if (exp_out) exp_q.push_back(w);
            end
            @(posedge clock);
            #1;
        end
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (n < 20) begin
            @(negedge clock);
            if (out_valid) break;
            @(posedge clock);
            n++;
        end
    endtask

    task automatic drain();
        int t = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clock);
            #1;
            t++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int acc;

        // Reset values
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_stage_valid", stage_valid, 0);
        chk("rst_stage_data", stage_data[63:0], 0);
        chk("rst_occupancy", occupancy, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Streaming 0x1..0x8 with out_ready held high
        out_ready = 1'b1;
        send(32'h1, 1'b1);
        fork
            wait_out(lat);
            begin
                for (int w = 2; w <= 8; w++) send(DATA_W'(w), 1'b1);
                chk("stream_occupancy", occupancy, 5);
                in_valid = 1'b0;
            end
        join
        chk("stream_latency", lat, 4);
        drain();

        // Backpressure: 10 cycles of in_valid with out_ready low
        out_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = 32'hC0 + DATA_W'(acc);
            @(negedge clock);
            if (in_ready) begin
                exp_q.push_back(in_data);
                acc++;
            end
            @(posedge clock);
            #1;
        end
        chk("bp_accepts", acc, 5);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_occupancy", occupancy, 5);
        drain();

        // Kill stage 2 of a full chain: 0xA2 sits there and must vanish
        out_ready = 1'b0;
        send(32'hA0, 1'b1);
        send(32'hA1, 1'b1);
        send(32'hA2, 1'b0);
        send(32'hA3, 1'b1);
        send(32'hA4, 1'b1);
        in_valid = 1'b0;
        kill = 5'b00100;
        @(negedge clock);
        chk("kill_occ_same_cycle", occupancy, 5);
        @(posedge clock);
        #1;
        kill = '0;
        chk("kill_occ_after", occupancy, 4);
        drain();

        // Flush a full chain while presenting a word
        out_ready = 1'b0;
        for (int w = 0; w < 5; w++) send(32'hD0 + DATA_W'(w), 1'b0);
        in_valid  = 1'b1;
        in_data   = 32'hDEAD;
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        chk("flush_in_ready", in_ready, 0);
        chk("flush_out_valid", out_valid, 0);
        @(posedge clock);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_stage_valid", stage_valid, 0);
        chk("flush_occupancy", occupancy, 0);
        repeat (8) @(posedge clock);
        #1;

        // Reset mid-operation with three words resident
        out_ready = 1'b0;
        send(32'h11, 1'b0);
        send(32'h22, 1'b0);
        send(32'h33, 1'b0);
        in_valid = 1'b0;
        chk("pre_rst_occupancy", occupancy, 3);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_occupancy", occupancy, 0);
        chk("mid_rst_stage_valid", stage_valid, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_stage_data", stage_data[63:0], 0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        send(32'h55, 1'b1);
        in_valid = 1'b0;
        wait_out(lat);
        chk("post_rst_latency", lat, 4);
        @(posedge clock);
        #1;
        drain();

        // Random valid/ready traffic against a FIFO model
        occ_chk = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            @(negedge clock);
            if (in_valid && in_ready) exp_q.push_back(in_data);
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        drain();
        occ_chk = 1'b0;
        chk("final_occupancy", occupancy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
